uart_frame_rx: RTL and testbench

- Serial frame receiver: the receive end of the team's framed UART link.
- Deserialises the line into bytes and hunts for the sync byte. Then captures OPT, LEN, LEN payload bytes and a 4-byte CRC-32.
- Presents {OPT, LEN, payload} on a valid/ready output word with CRC and error status.
- Sits between the pad-side RX line and the command decoder.

---
 rtl/uart_frame_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: framed UART receiver (sync hunt, OPT, LEN, payload, CRC-32) with valid/ready output.
// Defining UART_FRAME_RX_TIMEOUT_EN adds an inter-byte idle timeout that aborts a stalled frame.
module uart_frame_rx #(
    parameter int         FULL_DATA_SIZE = 40,
    parameter int         BYTE_SIZE      = 8,
    parameter int         CLKS_PER_BIT   = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hFE
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      in_bit,
    output logic [FULL_DATA_SIZE-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_crc_err,
    output logic                      frame_err,
    output logic                      len_err,
    output logic                      overrun
);
    localparam int USEFUL_DATA_SIZE = FULL_DATA_SIZE - 2*BYTE_SIZE;
    localparam int MAX_LEN          = USEFUL_DATA_SIZE / BYTE_SIZE;
    localparam int IDX_W            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W            = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_HUNT, ST_OPT, ST_LEN, ST_DATA, ST_CSM, ST_OUT} st_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [BYTE_SIZE-1:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < BYTE_SIZE; i++) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    rx_state_t              rx_st_q, rx_st_d;
    logic                   sync_p0, sync_p1, line_p2;
    logic [CNT_W-1:0]       clk_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [BYTE_SIZE-1:0]   shreg_q;
    logic                   half_done, bit_done, byte_stb, good_byte, bad_byte;

    st_t                    st_q, st_d;
    logic [BYTE_SIZE-1:0]   opt_q, len_q;
    logic [USEFUL_DATA_SIZE-1:0] payload_q;
    logic [IDX_W-1:0]       idx_q;
    logic [1:0]             csm_cnt_q;
    logic [31:0]            crc_q, rx_crc_q;
    logic                   timeout, frame_err_d, len_err_d;

    assign half_done = (clk_cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1));
    assign bit_done  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign byte_stb  = (rx_st_q == RX_STOP) && bit_done;
    assign good_byte = byte_stb && sync_p1;
    assign bad_byte  = byte_stb && !sync_p1;

    // Stage p0/p1: line synchroniser; p2 holds the previous sample for edge detect
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            line_p2   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            sync_p0 <= in_bit;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
            rx_st_q <= rx_st_d;
            if (rx_st_q == RX_IDLE || rx_st_d != rx_st_q || bit_done)
                clk_cnt_q <= '0;
            else
                clk_cnt_q <= clk_cnt_q + CNT_W'(1);
            if (rx_st_q == RX_DATA && bit_done)
                bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_st_q == RX_DATA && bit_done)
            shreg_q <= {sync_p1, shreg_q[BYTE_SIZE-1:1]};
    end

    always_comb begin
        rx_st_d = rx_st_q;
        case (rx_st_q)
            RX_IDLE:  if (line_p2 && !sync_p1) rx_st_d = RX_START;
            // A start bit that is high again at mid-bit was a glitch
            RX_START: if (half_done) rx_st_d = sync_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_done && bit_cnt_q == 3'd7) rx_st_d = RX_STOP;
            RX_STOP:  if (bit_done) rx_st_d = RX_IDLE;
            default:  rx_st_d = RX_IDLE;
        endcase
    end

`ifdef UART_FRAME_RX_TIMEOUT_EN
    localparam int TIMEOUT_CLKS = 20*CLKS_PER_BIT;
    logic [15:0] idle_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N || st_q == ST_HUNT || byte_stb)
            idle_cnt_q <= '0;
        else
            idle_cnt_q <= idle_cnt_q + 16'd1;
    end

    assign timeout = (st_q != ST_HUNT) && (idle_cnt_q == 16'(TIMEOUT_CLKS - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        st_d        = st_q;
        frame_err_d = 1'b0;
        len_err_d   = 1'b0;
        if ((bad_byte && st_q != ST_HUNT) || timeout) begin
            st_d        = ST_HUNT;
            frame_err_d = 1'b1;
        end else begin
            case (st_q)
                ST_HUNT: if (good_byte && shreg_q == SYNC_BYTE) st_d = ST_OPT;
                ST_OPT:  if (good_byte) st_d = ST_LEN;
                ST_LEN:
                    if (good_byte) begin
                        if (shreg_q > BYTE_SIZE'(MAX_LEN)) begin
                            st_d      = ST_HUNT;
                            len_err_d = 1'b1;
                        end else if (shreg_q == '0) begin
                            st_d = ST_CSM;
                        end else begin
                            st_d = ST_DATA;
                        end
                    end
                ST_DATA: if (good_byte && BYTE_SIZE'(idx_q) == len_q - BYTE_SIZE'(1)) st_d = ST_CSM;
                ST_CSM:  if (good_byte && csm_cnt_q == 2'd3) st_d = ST_OUT;
                ST_OUT:  st_d = ST_HUNT;
                default: st_d = ST_HUNT;
            endcase
        end
    end

    // Frame control, CRC accumulation and output handshake
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            st_q        <= ST_HUNT;
            idx_q       <= '0;
            csm_cnt_q   <= '0;
            crc_q       <= '1;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_crc_err <= 1'b0;
            frame_err   <= 1'b0;
            len_err     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            st_q      <= st_d;
            frame_err <= frame_err_d;
            len_err   <= len_err_d;
            overrun   <= 1'b0;
            if (good_byte && !timeout) begin
                case (st_q)
                    ST_HUNT:
                        if (shreg_q == SYNC_BYTE) begin
                            crc_q     <= '1;
                            idx_q     <= '0;
                            csm_cnt_q <= '0;
                        end
                    ST_OPT, ST_LEN: crc_q <= crc32_byte(crc_q, shreg_q);
                    ST_DATA: begin
                        crc_q <= crc32_byte(crc_q, shreg_q);
                        idx_q <= idx_q + IDX_W'(1);
                    end
                    ST_CSM:  csm_cnt_q <= csm_cnt_q + 2'd1;
                    default: ;
                endcase
            end
            if (st_q == ST_OUT) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out_valid   <= 1'b1;
                    out_data    <= {opt_q, len_q, payload_q};
                    out_crc_err <= (crc_q != rx_crc_q);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (good_byte) begin
            case (st_q)
                ST_OPT: opt_q <= shreg_q;
                ST_LEN: begin
                    len_q     <= shreg_q;
                    payload_q <= '0;
                end
                ST_DATA:
                    for (int k = 0; k < MAX_LEN; k++)
                        if (idx_q == IDX_W'(k))
                            payload_q[USEFUL_DATA_SIZE-1-BYTE_SIZE*k -: BYTE_SIZE] <= shreg_q;
                ST_CSM:  rx_crc_q <= {rx_crc_q[23:0], shreg_q};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx: framing, CRC, LEN limits, overrun, errors, reset.
module tb_uart_frame_rx;
    localparam int CPB = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_bit = 1'b1;
    logic        out_ready = 1'b0;
    logic [39:0] out_data;
    logic        out_valid, out_crc_err, frame_err, len_err, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int          fe_cnt = 0, le_cnt = 0, ov_cnt = 0, acc_cnt = 0, vld_cycles = 0;
    logic [39:0] acc_data = '0;
    logic        acc_crc_err = 1'b0;

    always #5 CLK = ~CLK;

    uart_frame_rx dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_bit      (in_bit),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_crc_err (out_crc_err),
        .frame_err   (frame_err),
        .len_err     (len_err),
        .overrun     (overrun)
    );

    // Event monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (RST_N) begin
            if (frame_err) fe_cnt++;
            if (len_err)   le_cnt++;
            if (overrun)   ov_cnt++;
            if (out_valid) vld_cycles++;
            if (out_valid && out_ready) begin
                acc_cnt++;
                acc_data    = out_data;
                acc_crc_err = out_crc_err;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic v);
        in_bit = v;
        repeat (CPB) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
        send_bit(1'b1);
    endtask

    // Reference CRC over the line-order bit stream of OPT, LEN and payload
    function automatic logic [31:0] crc_model(input logic [7:0] opt, input logic [7:0] len,
                                              input logic [23:0] pl);
        logic [7:0]  stream[$];
        logic [31:0] c;
        logic        fb;
        stream.push_back(opt);
        stream.push_back(len);
        for (int k = 0; k < int'(len); k++) stream.push_back(pl[23-8*k -: 8]);
        c = 32'hFFFFFFFF;
        foreach (stream[j]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ stream[j][i];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    task automatic send_frame(input logic [7:0] opt, input logic [7:0] len,
                              input logic [23:0] pl, input logic [7:0] flip);
        logic [31:0] crc;
        crc = crc_model(opt, len, pl);
        send_byte(8'hFE, 1'b1);
        send_byte(opt, 1'b1);
        send_byte(len, 1'b1);
        for (int k = 0; k < int'(len); k++) send_byte(pl[23-8*k -: 8], 1'b1);
        send_byte(crc[31:24], 1'b1);
        send_byte(crc[23:16], 1'b1);
        send_byte(crc[15:8], 1'b1);
        send_byte(crc[7:0] ^ flip, 1'b1);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        in_bit = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_data !== 40'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want %h", out_data, 40'h0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_crc_err: got %b want 0", out_crc_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b want 0", len_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        RST_N = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_good_frame();
        int acc0, vld0, fe0;
        out_ready = 1'b1;
        acc0 = acc_cnt; vld0 = vld_cycles; fe0 = fe_cnt;
        send_frame(8'h11, 8'h02, 24'hA53C00, 8'h00);
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL good_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (vld_cycles - vld0 !== 1) begin n_fail++; $display("FAIL good_valid_cycles: got %0d want 1", vld_cycles - vld0); end
        n_checks++; if (acc_data !== 40'h1102A53C00) begin n_fail++; $display("FAIL good_data: got %h want %h", acc_data, 40'h1102A53C00); end
        n_checks++; if (acc_crc_err !== 1'b0) begin n_fail++; $display("FAIL good_crc_err: got %b want 0", acc_crc_err); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL good_frame_err: got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_crc_err();
        int acc0;
        acc0 = acc_cnt;
        send_frame(8'h11, 8'h02, 24'hA53C00, 8'h01);
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL crcerr_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (acc_data !== 40'h1102A53C00) begin n_fail++; $display("FAIL crcerr_data: got %h want %h", acc_data, 40'h1102A53C00); end
        n_checks++; if (acc_crc_err !== 1'b1) begin n_fail++; $display("FAIL crcerr_flag: got %b want 1", acc_crc_err); end
    endtask

    task automatic test_junk_sync();
        int acc0, fe0, le0;
        acc0 = acc_cnt; fe0 = fe_cnt; le0 = le_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_frame(8'h05, 8'h00, 24'h000000, 8'h00);
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL junk_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (acc_data !== 40'h0500000000) begin n_fail++; $display("FAIL junk_data: got %h want %h", acc_data, 40'h0500000000); end
        n_checks++; if (acc_crc_err !== 1'b0) begin n_fail++; $display("FAIL junk_crc_err: got %b want 0", acc_crc_err); end
        n_checks++; if ((fe_cnt - fe0) + (le_cnt - le0) !== 0) begin n_fail++; $display("FAIL junk_errors: got %0d want 0", (fe_cnt - fe0) + (le_cnt - le0)); end
    endtask

    task automatic test_len_max();
        int acc0;
        acc0 = acc_cnt;
        send_frame(8'h22, 8'h03, 24'hDEADBE, 8'h00);
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL lenmax_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (acc_data !== 40'h2203DEADBE) begin n_fail++; $display("FAIL lenmax_data: got %h want %h", acc_data, 40'h2203DEADBE); end
        n_checks++; if (acc_crc_err !== 1'b0) begin n_fail++; $display("FAIL lenmax_crc_err: got %b want 0", acc_crc_err); end
    endtask

    task automatic test_len_err();
        int acc0, le0, fe0;
        acc0 = acc_cnt; le0 = le_cnt; fe0 = fe_cnt;
        send_byte(8'hFE, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (8) tick();
        n_checks++; if (le_cnt - le0 !== 1) begin n_fail++; $display("FAIL lenerr_pulse: got %0d want 1", le_cnt - le0); end
        n_checks++; if (acc_cnt - acc0 !== 0) begin n_fail++; $display("FAIL lenerr_no_output: got %0d want 0", acc_cnt - acc0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lenerr_valid: got %b want 0", out_valid); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL lenerr_frame_err: got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_overrun();
        int ov0, acc0;
        out_ready = 1'b0;
        ov0 = ov_cnt; acc0 = acc_cnt;
        send_frame(8'h11, 8'h01, 24'h770000, 8'h00);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 40'h1101770000) begin n_fail++; $display("FAIL ovr_first_data: got %h want %h", out_data, 40'h1101770000); end
        send_frame(8'h33, 8'h00, 24'h000000, 8'h00);
        n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - ov0); end
        n_checks++; if (out_data !== 40'h1101770000) begin n_fail++; $display("FAIL ovr_retained_data: got %h want %h", out_data, 40'h1101770000); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_still_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (acc_data !== 40'h1101770000) begin n_fail++; $display("FAIL ovr_accepted_data: got %h want %h", acc_data, 40'h1101770000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", out_valid); end
        repeat (4) tick();
    endtask

    task automatic test_frame_err();
        int fe0, acc0;
        fe0 = fe_cnt; acc0 = acc_cnt;
        send_byte(8'hFE, 1'b1);
        send_byte(8'h44, 1'b0);
        repeat (4) tick();
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0); end
        n_checks++; if (acc_cnt - acc0 !== 0) begin n_fail++; $display("FAIL ferr_no_output: got %0d want 0", acc_cnt - acc0); end
        send_frame(8'h44, 8'h01, 24'h5A0000, 8'h00);
        n_checks++; if (acc_data !== 40'h44015A0000) begin n_fail++; $display("FAIL ferr_recover_data: got %h want %h", acc_data, 40'h44015A0000); end
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_recover_clean: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int fe0, acc0;
        logic [31:0] crc;
        fe0 = fe_cnt; acc0 = acc_cnt;
        crc = crc_model(8'h55, 8'h02, 24'h123400);
        send_byte(8'hFE, 1'b1);
        in_bit = 1'b0;
        repeat (3) tick();
        send_bit(1'b1);
        send_bit(1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(crc[31:24], 1'b1);
        send_byte(crc[23:16], 1'b1);
        send_byte(crc[15:8], 1'b1);
        send_byte(crc[7:0], 1'b1);
        repeat (4) tick();
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL glitch_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (acc_data !== 40'h5502123400) begin n_fail++; $display("FAIL glitch_data: got %h want %h", acc_data, 40'h5502123400); end
        n_checks++; if (acc_crc_err !== 1'b0) begin n_fail++; $display("FAIL glitch_crc_err: got %b want 0", acc_crc_err); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fe0); end
    endtask

    task automatic test_reset_mid();
        int acc0;
        send_byte(8'hFE, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hA5, 1'b1);
        RST_N = 1'b0;
        tick();
        n_checks++; if (out_data !== 40'h0) begin n_fail++; $display("FAIL rstmid_out_data: got %h want %h", out_data, 40'h0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_crc_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_crc_err: got %b want 0", out_crc_err); end
        RST_N = 1'b1;
        repeat (2) tick();
        acc0 = acc_cnt;
        send_frame(8'h11, 8'h02, 24'hA53C00, 8'h00);
        n_checks++; if (acc_cnt - acc0 !== 1) begin n_fail++; $display("FAIL rstmid_accept_count: got %0d want 1", acc_cnt - acc0); end
        n_checks++; if (acc_data !== 40'h1102A53C00) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", acc_data, 40'h1102A53C00); end
        n_checks++; if (acc_crc_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_crc_err_after: got %b want 0", acc_crc_err); end
    endtask

`ifdef UART_FRAME_RX_TIMEOUT_EN
    task automatic test_timeout();
        int fe0, waited;
        fe0 = fe_cnt;
        send_byte(8'hFE, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (250) tick();
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d want 0", fe_cnt - fe0); end
        waited = 0;
        while (fe_cnt == fe0 && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d want 1", fe_cnt - fe0); end
        repeat (4) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_crc_err();
        test_junk_sync();
        test_len_max();
        test_len_err();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef UART_FRAME_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
